decoder_rr_arbiter: RTL
=======================

# decoder_rr_arbiter

Round-robin arbiter that shares the 2-to-4 decoder select path between four requesters. It picks one requester, holds the grant while that requester keeps its request asserted, and caps hold time when others are waiting. Between grants it inserts one dead cycle with enable low. Outputs `gnt_idx`/`gnt_en` drive the decoder's `a`/`en` inputs directly. `gnt` is the registered one-hot equivalent, for requesters that need their own grant line.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another request is pending. Legal range ≥1; elaboration error otherwise.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request per requester; level, held high while access is wanted.
- `gnt_idx` out 2: granted requester index; feeds decoder `a`.
- `gnt_en` out 1: grant valid; feeds decoder `en`.
- `gnt` out 4: one-hot grant, equal to `gnt_en ? (1 << gnt_idx) : 0`.
- `preempt` out 1: one-cycle pulse during a GAP cycle that was caused by a hold-limit preemption.

## Operation
- Internal state:
  - FSM: IDLE, GRANT, GAP.
  - `ptr[1:0]`: highest-priority index.
  - `hold_cnt`: width clog2(MAX_HOLD+1), saturating at MAX_HOLD.
- Arbitration function, used in IDLE and GAP: select the first set bit of `req` scanning ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE:
  - If `req`==0, remain in IDLE.
  - Otherwise go to GRANT with `gnt_idx`=selected, `gnt_en`=1, `hold_cnt`=1.
- GRANT, evaluated each cycle in priority order:
  1. Release: `req[gnt_idx]`==0. Go to GAP, set `ptr`=gnt_idx+1 (mod 4), `preempt`=0.
  2. Preempt: `hold_cnt`==MAX_HOLD and any other `req` bit is set. Go to GAP, set `ptr`=gnt_idx+1, `preempt`=1.
  3. Otherwise stay in GRANT and increment `hold_cnt`, saturating at MAX_HOLD.
- A sole requester with no competitor is never preempted. `hold_cnt` stays at MAX_HOLD and the grant persists.
- GAP:
  - Lasts exactly one cycle with `gnt_en`=0 and `gnt`=0.
  - Arbitration runs on `req` sampled in this cycle. Any request goes to GRANT (new selection, `hold_cnt`=1); none goes to IDLE.
  - The requester just released or preempted can win again only if no other request is set, because `ptr` has moved past it.
- `gnt_idx` holds its last value while `gnt_en`=0.
- `gnt_idx`, `gnt_en`, `gnt` and `preempt` are all registered. There is no combinational path from `req` to any output.

## Timing
- Reset values: state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt_idx`=0, `gnt_en`=0, `gnt`=4'b0000, `preempt`=0.
- Reset asserts asynchronously, including mid-grant: outputs drop immediately.
- First edge after `rst_n` deasserts behaves as IDLE.
- Grant latency from IDLE: `req` high at edge k, grant visible after edge k, i.e. 1 cycle.
- Release: `req[gnt_idx]` low sampled at edge t.
  - `gnt_en`=0 after edge t (GAP cycle).
  - The next grant appears after edge t+1.
  - Grant-to-grant switch therefore always includes exactly one idle cycle.
- Preemption: the grant lasts exactly MAX_HOLD cycles, then one GAP cycle with `preempt`=1, then the next requester.
- Simultaneous release and preemption resolve as release (`preempt`=0).
- A request that rises and falls entirely within a GRANT period is not remembered. Requests are levels, not queued events.

## Test plan
1. Reset: drive `req`=4'b1111 with `rst_n`=0. Required: `gnt_en`=0, `gnt`=0, `gnt_idx`=0, `preempt`=0; first grant after release is idx 0, `gnt`=4'b0001.
2. Single requester: `req`=4'b0100 for 20 cycles with MAX_HOLD=4, then low.
   - Grant idx 2 one cycle after the request.
   - No preemption across the 20 cycles.
   - `gnt_en` drops one cycle after the request drops; then IDLE.
3. Rotation: `req`=4'b1111, each requester releases after 2 granted cycles and re-asserts immediately.
   - Grant order 0,1,2,3,0.
   - Each grant 2 cycles, each followed by one GAP cycle.
4. Preemption with MAX_HOLD=4: `req`=4'b0011 held high permanently.
   - idx 0 granted 4 cycles, GAP with `preempt`=1, idx 1 granted 4 cycles, GAP with `preempt`=1, idx 0 again.
5. Wrap and skip: grant idx 3, then release with `req`=4'b0101. Required: after GAP, idx 0 granted (ptr wrapped to 0).
6. Reset mid-operation: assert `rst_n`=0 asynchronously in the middle of a grant with `hold_cnt`=3. Required: outputs drop to 0 before the next edge; after release, `ptr`=0 and `hold_cnt` restarts at 1.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving the 2-to-4 decoder select path.
// One dead cycle between grants; hold time capped while others wait.
module decoder_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [1:0] gnt_idx,
   output logic       gnt_en,
   output logic [3:0] gnt,
   output logic       preempt
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("MAX_HOLD must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   state_t        state, state_n;
   logic [1:0]    ptr, ptr_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [1:0]    idx_n;
   logic          en_n;
   logic          pre_n;
   logic [3:0]    gnt_n;

   logic          sel_ok;
   logic [1:0]    sel_idx;
   logic [1:0]    cand;
   logic          others;

   // Scan from the far end so the lowest offset from ptr wins.
   always_comb begin
      sel_ok  = 1'b0;
      sel_idx = ptr;
      cand    = ptr;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (req[cand]) begin
            sel_ok  = 1'b1;
            sel_idx = cand;
         end
      end
   end

   assign others = |(req & ~gnt);

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      idx_n   = gnt_idx;
      en_n    = gnt_en;
      pre_n   = 1'b0;
      case (state)
         IDLE, GAP: begin
            if (sel_ok) begin
               state_n = GRANT;
               idx_n   = sel_idx;
               en_n    = 1'b1;
               hold_n  = HW'(1);
            end else begin
               state_n = IDLE;
               en_n    = 1'b0;
            end
         end
         GRANT: begin
            if (!req[gnt_idx]) begin
               state_n = GAP;
               ptr_n   = gnt_idx + 2'd1;
               en_n    = 1'b0;
               hold_n  = '0;
            end else if (hold_cnt == HMAX && others) begin
               state_n = GAP;
               ptr_n   = gnt_idx + 2'd1;
               en_n    = 1'b0;
               hold_n  = '0;
               pre_n   = 1'b1;
            end else if (hold_cnt != HMAX) begin
               hold_n = hold_cnt + HW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            en_n    = 1'b0;
         end
      endcase
      gnt_n = en_n ? (4'b0001 << idx_n) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         hold_cnt <= '0;
         gnt_idx  <= 2'd0;
         gnt_en   <= 1'b0;
         gnt      <= 4'b0000;
         preempt  <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         gnt_idx  <= idx_n;
         gnt_en   <= en_n;
         gnt      <= gnt_n;
         preempt  <= pre_n;
      end
   end

endmodule
